biu_burst_sequencer: RTL and testbench

Parametrised burst address sequencer for the bus interface unit. It accepts one transfer command (start address, `biu_size_t`, `biu_type_t`, `biu_prot_t`, direction) and expands it into a stream of per-beat addresses with first/last markers and a valid/ready handshake. It generalises the size/burst/protection encodings to any data width and to length-programmable INCR bursts, and adds wrap addressing, legality checking and abort. It sits between the cache/LSU command side and the bus-specific master (AHB/AXI adapter).

---
 rtl/biu_constants_pkg.sv | 58 +++++
 rtl/biu_burst_adr_calc.sv | 33 +++
 rtl/biu_burst_sequencer.sv | 169 ++++++++++++++++
 tb/tb_biu_burst_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/biu_constants_pkg.sv
// Shared bus-interface-unit encodings and burst helpers.
// Used by the burst sequencer and its address calculator.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE   = 3'd0,
        HWORD  = 3'd1,
        WORD   = 3'd2,
        DWORD  = 3'd3,
        QWORD  = 3'd4,
        OWORD  = 3'd5,
        HOWORD = 3'd6,
        KWORD  = 3'd7
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;

    localparam biu_prot_t PROT_DATA       = 3'b001;
    localparam biu_prot_t PROT_PRIVILEGED = 3'b010;
    localparam biu_prot_t PROT_CACHEABLE  = 3'b100;

    localparam int unsigned BIU_BOUNDARY = 1024;

    // Registered per-burst attributes carried alongside the running address.
    typedef struct packed {
        biu_size_t size;
        biu_type_t btype;
        biu_prot_t prot;
        logic      we;
    } biu_attr_t;

    // Fixed beat count; INCR is length-programmed and reports 0.
    function automatic int unsigned biu_beats(input biu_type_t t);
        case (t)
            SINGLE:        return 1;
            WRAP4, INCR4:  return 4;
            WRAP8, INCR8:  return 8;
            WRAP16, INCR16: return 16;
            default:       return 0;
        endcase
    endfunction

    function automatic logic biu_wrap(input biu_type_t t);
        return (t == WRAP4) || (t == WRAP8) || (t == WRAP16);
    endfunction

endpackage

// File: rtl/biu_burst_adr_calc.sv
// Combinational next-beat address and 1 KiB boundary-cross check for a burst.
module biu_burst_adr_calc
    import biu_constants_pkg::*;
#(
    parameter int unsigned PLEN = 32,
    parameter int unsigned LW   = 5
) (
    input  logic [PLEN-1:0] adr_i,
    input  biu_size_t       size_i,
    input  logic [LW-1:0]   beats_i,
    input  logic            wrap_i,
    output logic [PLEN-1:0] nxt_adr_o,
    output logic            cross_o
);

    localparam int unsigned BW = $clog2(BIU_BOUNDARY);

    logic [PLEN-1:0] step;
    logic [PLEN-1:0] mask;
    logic [PLEN-1:0] inc;
    logic [PLEN-1:0] last_byte;

    // mask spans the whole burst; wrap keeps the upper bits fixed
    always_comb begin
        step      = PLEN'(1) << size_i;
        mask      = (PLEN'(beats_i) << size_i) - PLEN'(1);
        inc       = adr_i + step;
        last_byte = adr_i + mask;
        nxt_adr_o = wrap_i ? ((adr_i & ~mask) | (inc & mask)) : inc;
        cross_o   = !wrap_i && (adr_i[PLEN-1:BW] != last_byte[PLEN-1:BW]);
    end

endmodule

// File: rtl/biu_burst_sequencer.sv
// Expands one transfer command into a handshaked stream of per-beat addresses.
// Supports fixed/length-programmed INCR, WRAP, legality rejection and abort.
module biu_burst_sequencer
    import biu_constants_pkg::*;
#(
    parameter int unsigned PLEN     = 32,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned INCR_MAX = 16,
    localparam int unsigned LW      = $clog2(INCR_MAX + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cmd_req_i,
    output logic            cmd_ack_o,
    input  logic [PLEN-1:0] cmd_adr_i,
    input  biu_size_t       cmd_size_i,
    input  biu_type_t       cmd_type_i,
    input  logic [LW-1:0]   cmd_len_i,
    input  logic            cmd_we_i,
    input  biu_prot_t       cmd_prot_i,
    output logic            err_o,
    output logic            beat_valid_o,
    input  logic            beat_ready_i,
    output logic [PLEN-1:0] beat_adr_o,
    output biu_size_t       beat_size_o,
    output logic            beat_we_o,
    output biu_prot_t       beat_prot_o,
    output logic            beat_first_o,
    output logic            beat_last_o,
    output logic [LW-1:0]   beat_idx_o,
    input  logic            abort_i,
    output logic            busy_o
);

    localparam int unsigned MAX_SIZE = $clog2(XLEN / 8);
    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_BURST = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PLEN-1:0] adr_q, adr_d;
    biu_attr_t       attr_q, attr_d;
    logic [LW-1:0]   beats_q, beats_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic            first_q, first_d;
    logic            last_q, last_d;

    logic [LW-1:0]   cmd_beats;
    logic            type_ok, size_ok, len_ok, aligned, illegal;
    logic            hs, accept;
    logic [PLEN-1:0] run_nxt, chk_nxt;
    logic            run_cross, chk_cross;
    logic            unused_calc;

    biu_burst_adr_calc #(.PLEN(PLEN), .LW(LW)) u_run_calc (
        .adr_i     (adr_q),
        .size_i    (attr_q.size),
        .beats_i   (beats_q),
        .wrap_i    (biu_wrap(attr_q.btype)),
        .nxt_adr_o (run_nxt),
        .cross_o   (run_cross)
    );

    biu_burst_adr_calc #(.PLEN(PLEN), .LW(LW)) u_chk_calc (
        .adr_i     (cmd_adr_i),
        .size_i    (cmd_size_i),
        .beats_i   (cmd_beats),
        .wrap_i    (biu_wrap(cmd_type_i)),
        .nxt_adr_o (chk_nxt),
        .cross_o   (chk_cross)
    );

    assign unused_calc = ^{chk_nxt, run_cross};

    // Command legality; unknown encodings fall through to the rejecting defaults.
    always_comb begin
        cmd_beats = LW'(biu_beats(cmd_type_i));
        type_ok   = 1'b0;
        size_ok   = 1'b0;
        len_ok    = 1'b1;
        case (cmd_type_i)
            SINGLE, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16: type_ok = 1'b1;
            INCR: begin
                type_ok   = 1'b1;
                cmd_beats = cmd_len_i;
                len_ok    = 1'b0;
                if ((cmd_len_i != '0) && (cmd_len_i <= LW'(INCR_MAX))) len_ok = 1'b1;
            end
            default: ;
        endcase
        if (cmd_size_i <= 3'(MAX_SIZE)) size_ok = 1'b1;
        aligned = (cmd_adr_i & ((PLEN'(1) << cmd_size_i) - PLEN'(1))) == '0;
        illegal = !(type_ok && size_ok && len_ok && aligned && !chk_cross);
    end

    assign hs        = (state_q == ST_BURST) && beat_ready_i;
    assign cmd_ack_o = cmd_req_i && ((state_q == ST_IDLE) || (hs && last_q && !abort_i));
    assign err_o     = cmd_ack_o && illegal;
    assign accept    = cmd_ack_o && !illegal;

    // Next state; a legal accept always (re)loads the burst, giving zero-bubble chaining.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        attr_d  = attr_q;
        beats_d = beats_q;
        idx_d   = idx_q;
        first_d = first_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: ;
            ST_BURST: begin
                if (abort_i || (hs && last_q)) begin
                    state_d = ST_IDLE;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                end else if (hs) begin
                    adr_d   = run_nxt;
                    idx_d   = idx_q + LW'(1);
                    first_d = 1'b0;
                    last_d  = (idx_q + LW'(2)) == beats_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d      = ST_BURST;
            adr_d        = cmd_adr_i;
            attr_d.size  = cmd_size_i;
            attr_d.btype = cmd_type_i;
            attr_d.prot  = cmd_prot_i;
            attr_d.we    = cmd_we_i;
            beats_d      = cmd_beats;
            idx_d        = '0;
            first_d      = 1'b1;
            last_d       = cmd_beats == LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            adr_q   <= '0;
            attr_q  <= '{size: BYTE, btype: SINGLE, prot: '0, we: 1'b0};
            beats_q <= '0;
            idx_q   <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            attr_q  <= attr_d;
            beats_q <= beats_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    assign beat_valid_o = state_q == ST_BURST;
    assign busy_o       = state_q == ST_BURST;
    assign beat_adr_o   = adr_q;
    assign beat_size_o  = attr_q.size;
    assign beat_we_o    = attr_q.we;
    assign beat_prot_o  = attr_q.prot;
    assign beat_first_o = first_q;
    assign beat_last_o  = last_q;
    assign beat_idx_o   = idx_q;

endmodule

// File: tb/tb_biu_burst_sequencer.sv
// Directed scoreboard bench for biu_burst_sequencer: expected beats are queued
// from an independent burst model when a command is accepted, popped on handshakes.
module tb_biu_burst_sequencer;
    import biu_constants_pkg::*;

    localparam int unsigned LW = 5;

    typedef struct packed {
        logic [31:0] adr;
        logic        first;
        logic        last;
        logic [4:0]  idx;
        biu_size_t   size;
        logic        we;
        biu_prot_t   prot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        cmd_req_i;
    logic        cmd_ack_o;
    logic [31:0] cmd_adr_i;
    biu_size_t   cmd_size_i;
    biu_type_t   cmd_type_i;
    logic [LW-1:0] cmd_len_i;
    logic        cmd_we_i;
    biu_prot_t   cmd_prot_i;
    logic        err_o;
    logic        beat_valid_o;
    logic        beat_ready_i;
    logic [31:0] beat_adr_o;
    biu_size_t   beat_size_o;
    logic        beat_we_o;
    biu_prot_t   beat_prot_o;
    logic        beat_first_o;
    logic        beat_last_o;
    logic [LW-1:0] beat_idx_o;
    logic        abort_i;
    logic        busy_o;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sb[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_adr = '0;
    logic        toggle_ready = 1'b0;

    always #5 clk = ~clk;

    biu_burst_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_req_i    (cmd_req_i),
        .cmd_ack_o    (cmd_ack_o),
        .cmd_adr_i    (cmd_adr_i),
        .cmd_size_i   (cmd_size_i),
        .cmd_type_i   (cmd_type_i),
        .cmd_len_i    (cmd_len_i),
        .cmd_we_i     (cmd_we_i),
        .cmd_prot_i   (cmd_prot_i),
        .err_o        (err_o),
        .beat_valid_o (beat_valid_o),
        .beat_ready_i (beat_ready_i),
        .beat_adr_o   (beat_adr_o),
        .beat_size_o  (beat_size_o),
        .beat_we_o    (beat_we_o),
        .beat_prot_o  (beat_prot_o),
        .beat_first_o (beat_first_o),
        .beat_last_o  (beat_last_o),
        .beat_idx_o   (beat_idx_o),
        .abort_i      (abort_i),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent burst model: wrap addresses as base + (offset mod burst span).
    task automatic push_model(input logic [31:0] adr, input biu_size_t size, input biu_type_t t,
                              input int len, input logic we, input biu_prot_t prot);
        int          n;
        logic [31:0] step, total, base, a;
        exp_t        e;
        case (t)
            SINGLE:        n = 1;
            INCR:          n = len;
            WRAP4, INCR4:  n = 4;
            WRAP8, INCR8:  n = 8;
            default:       n = 16;
        endcase
        step  = 32'd1 << size;
        total = 32'(n) << size;
        base  = adr & ~(total - 32'd1);
        for (int i = 0; i < n; i++) begin
            if (t == WRAP4 || t == WRAP8 || t == WRAP16)
                a = base + ((adr - base + 32'(i) * step) % total);
            else
                a = adr + 32'(i) * step;
            e.adr   = a;
            e.first = (i == 0);
            e.last  = (i == n - 1);
            e.idx   = 5'(i);
            e.size  = size;
            e.we    = we;
            e.prot  = prot;
            sb.push_back(e);
        end
    endtask

    // One clock: sample outputs before the rising edge, then advance to the falling edge.
    task automatic cyc();
        exp_t e;
        #1;
        if (prev_stall) begin
            chk("hold_valid", 64'(beat_valid_o), 64'd1);
            chk("hold_adr", 64'(beat_adr_o), 64'(prev_adr));
        end
        if (beat_valid_o && beat_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(beat_valid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("beat_adr", 64'(beat_adr_o), 64'(e.adr));
                chk("beat_first", 64'(beat_first_o), 64'(e.first));
                chk("beat_last", 64'(beat_last_o), 64'(e.last));
                chk("beat_idx", 64'(beat_idx_o), 64'(e.idx));
                chk("beat_size", 64'(beat_size_o), 64'(e.size));
                chk("beat_we", 64'(beat_we_o), 64'(e.we));
                chk("beat_prot", 64'(beat_prot_o), 64'(e.prot));
            end
        end
        prev_stall = beat_valid_o && !beat_ready_i;
        prev_adr   = beat_adr_o;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_cmd(input logic [31:0] adr, input biu_size_t size, input biu_type_t t,
                             input int len, input logic we, input biu_prot_t prot);
        cmd_adr_i  = adr;
        cmd_size_i = size;
        cmd_type_i = t;
        cmd_len_i  = LW'(len);
        cmd_we_i   = we;
        cmd_prot_i = prot;
        cmd_req_i  = 1'b1;
    endtask

    task automatic issue(input logic [31:0] adr, input biu_size_t size, input biu_type_t t,
                         input int len, input logic we, input biu_prot_t prot);
        drive_cmd(adr, size, t, len, we, prot);
        #1;
        chk("issue_ack", 64'(cmd_ack_o), 64'd1);
        chk("issue_err", 64'(err_o), 64'd0);
        push_model(adr, size, t, len, we, prot);
        cyc();
        cmd_req_i = 1'b0;
        chk("first_latency", 64'(beat_valid_o), 64'd1);
    endtask

    task automatic reject(input string tag, input logic [31:0] adr, input biu_size_t size,
                          input biu_type_t t, input int len);
        drive_cmd(adr, size, t, len, 1'b0, '0);
        #1;
        chk({tag, "_ack"}, 64'(cmd_ack_o), 64'd1);
        chk({tag, "_err"}, 64'(err_o), 64'd1);
        cyc();
        cmd_req_i = 1'b0;
        chk({tag, "_no_beat"}, 64'(beat_valid_o), 64'd0);
        chk({tag, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic drain(input int max_cycles, input logic no_bubble);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) begin
            if (toggle_ready) beat_ready_i = ~beat_ready_i;
            if (no_bubble) chk("no_bubble", 64'(beat_valid_o), 64'd1);
            cyc();
        end
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(beat_valid_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_first"}, 64'(beat_first_o), 64'd0);
        chk({tag, "_last"}, 64'(beat_last_o), 64'd0);
        chk({tag, "_adr"}, 64'(beat_adr_o), 64'd0);
        chk({tag, "_idx"}, 64'(beat_idx_o), 64'd0);
        chk({tag, "_size"}, 64'(beat_size_o), 64'(BYTE));
        chk({tag, "_prot"}, 64'(beat_prot_o), 64'd0);
        chk({tag, "_err"}, 64'(err_o), 64'd0);
    endtask

    initial begin
        rst_ni       = 1'b0;
        cmd_req_i    = 1'b0;
        cmd_adr_i    = '0;
        cmd_size_i   = BYTE;
        cmd_type_i   = SINGLE;
        cmd_len_i    = '0;
        cmd_we_i     = 1'b0;
        cmd_prot_i   = '0;
        beat_ready_i = 1'b1;
        abort_i      = 1'b0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // WRAP4 WORD from 0x38
        issue(32'h38, WORD, WRAP4, 0, 1'b0, 3'b001);
        drain(10, 1'b1);
        #1;
        chk("wrap4_busy_drop", 64'(busy_o), 64'd0);
        chk("wrap4_valid_drop", 64'(beat_valid_o), 64'd0);
        @(negedge clk);

        // INCR len 5 HWORD with toggling ready
        beat_ready_i = 1'b1;
        issue(32'h100, HWORD, INCR, 5, 1'b1, 3'b010);
        beat_ready_i = 1'b0;
        toggle_ready = 1'b1;
        drain(30, 1'b0);
        toggle_ready = 1'b0;
        beat_ready_i = 1'b1;
        cyc();
        chk("incr5_idle", 64'(busy_o), 64'd0);

        // Illegal commands
        reject("cross_1k", 32'h3F0, WORD, INCR8, 0);
        reject("misaligned", 32'h2, WORD, SINGLE, 0);
        reject("oversize", 32'h0, DWORD, SINGLE, 0);
        reject("incr_len0", 32'h0, WORD, INCR, 0);

        // Back-to-back: SINGLE then INCR4 accepted on the last handshake
        issue(32'h10, WORD, SINGLE, 0, 1'b0, 3'b000);
        drive_cmd(32'h20, WORD, INCR4, 0, 1'b0, 3'b000);
        #1;
        chk("b2b_last", 64'(beat_last_o), 64'd1);
        chk("b2b_ack", 64'(cmd_ack_o), 64'd1);
        chk("b2b_err", 64'(err_o), 64'd0);
        push_model(32'h20, WORD, INCR4, 0, 1'b0, 3'b000);
        cyc();
        cmd_req_i = 1'b0;
        drain(10, 1'b1);
        #1;
        chk("b2b_idle", 64'(busy_o), 64'd0);
        @(negedge clk);

        // Abort on beat 2 of INCR16
        issue(32'h200, WORD, INCR16, 0, 1'b1, 3'b011);
        cyc();
        cyc();
        drive_cmd(32'h300, WORD, SINGLE, 0, 1'b0, 3'b000);
        abort_i = 1'b1;
        #1;
        chk("abort_beat_idx", 64'(beat_idx_o), 64'd2);
        chk("abort_no_ack", 64'(cmd_ack_o), 64'd0);
        cyc();
        abort_i   = 1'b0;
        cmd_req_i = 1'b0;
        chk("abort_valid", 64'(beat_valid_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_pending", 64'(sb.size()), 64'd13);
        sb.delete();

        // Asynchronous reset in the middle of a stalled WRAP8
        beat_ready_i = 1'b0;
        issue(32'h48, WORD, WRAP8, 0, 1'b1, 3'b111);
        cyc();
        cyc();
        #2;
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        prev_stall = 1'b0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_ni       = 1'b1;
        beat_ready_i = 1'b1;
        issue(32'h81, BYTE, SINGLE, 0, 1'b1, 3'b101);
        drain(5, 1'b1);
        #1;
        chk("post_reset_idle", 64'(busy_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
